// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM family: read-during-write modes
// and the post-reset clear sequencer states.
package ram_pkg;

  localparam int unsigned RDW_READ_OLD    = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } clr_state_t;

endpackage

// File: rtl/dp_ram_port_pipe.sv
// Per-port return path: captures the returned word for an accepted access,
// selects old or merged data by read-during-write mode, and optionally adds
// one output register stage. Returned data is held until the next valid.
module dp_ram_port_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned RDW_MODE  = 0,
  parameter int unsigned OUT_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc,
  input  logic [DATA_BITS-1:0] old_word,
  input  logic [DATA_BITS-1:0] new_word,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid
);

  localparam logic [DATA_BITS-1:0] NEW_SEL = (RDW_MODE == RDW_WRITE_FIRST) ? '1 : '0;

  logic                 v1_q;
  logic [DATA_BITS-1:0] d1_q;
  logic [DATA_BITS-1:0] ret_word;

  assign ret_word = (new_word & NEW_SEL) | (old_word & ~NEW_SEL);

  // First stage: valid pulse per accepted access, data held between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= acc;
      if (acc) d1_q <= ret_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                 v2_q;
      logic [DATA_BITS-1:0] d2_q;

      // Optional output stage: delays valid/data by one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end

      assign rd_valid = v2_q;
      assign rd_data  = d2_q;
    end else begin : g_noreg
      assign rd_valid = v1_q;
      assign rd_data  = d1_q;
    end
  endgenerate

endmodule

// File: rtl/dp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, deterministic
// same-address collision handling (port A wins shared bytes), selectable
// read-during-write return, optional output register and post-reset clear.
module dp_ram_be
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   busy,
  output logic                   collision,
  input  logic                   a_req,
  input  logic                   a_wr_en,
  input  logic [DATA_BITS/8-1:0] a_bytesel,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [DATA_BITS-1:0]   a_wr_data,
  output logic [DATA_BITS-1:0]   a_rd_data,
  output logic                   a_rd_valid,
  input  logic                   b_req,
  input  logic                   b_wr_en,
  input  logic [DATA_BITS/8-1:0] b_bytesel,
  input  logic [ADDR_BITS-1:0]   b_addr,
  input  logic [DATA_BITS-1:0]   b_wr_data,
  output logic [DATA_BITS-1:0]   b_rd_data,
  output logic                   b_rd_valid
);

  localparam int unsigned NB    = DATA_BITS / 8;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  clr_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q;

  logic                 a_acc, b_acc, a_we, b_we, same_addr;
  logic [DATA_BITS-1:0] a_old, b_old, a_new, b_new;

  assign busy      = (state_q == ST_CLEAR);
  assign a_acc     = a_req & ~busy;
  assign b_acc     = b_req & ~busy;
  assign a_we      = a_acc & a_wr_en;
  assign b_we      = b_acc & b_wr_en;
  assign same_addr = (a_addr == b_addr);
  assign a_old     = mem[a_addr];
  assign b_old     = mem[b_addr];

  // Clear sequencer next state: leave CLEAR once the last word is written
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && ptr_q == '1) state_d = ST_READY;
  end

  // Clear sequencer state and sweep pointer; reset restarts the sweep at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Post-write word seen by each port: B bytes applied first, A bytes override
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (b_we && same_addr && b_bytesel[i]) a_new[i*8 +: 8] = b_wr_data[i*8 +: 8];
      if (a_we && a_bytesel[i])              a_new[i*8 +: 8] = a_wr_data[i*8 +: 8];
      if (b_we && b_bytesel[i])              b_new[i*8 +: 8] = b_wr_data[i*8 +: 8];
      if (a_we && same_addr && a_bytesel[i]) b_new[i*8 +: 8] = a_wr_data[i*8 +: 8];
    end
  end

  // Storage writes: clear sweep, else byte writes with A issued last so it
  // takes the bytes both ports enable on a shared address
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (b_we && b_bytesel[i]) mem[b_addr][i*8 +: 8] <= b_wr_data[i*8 +: 8];
      end
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_we && a_bytesel[i]) mem[a_addr][i*8 +: 8] <= a_wr_data[i*8 +: 8];
      end
    end
  end

  // Collision flag: both ports wrote the same address on the previous edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= a_we & b_we & same_addr;
  end

  dp_ram_port_pipe #(
    .DATA_BITS (DATA_BITS),
    .RDW_MODE  (RDW_MODE),
    .OUT_REG   (OUT_REG)
  ) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc      (a_acc),
    .old_word (a_old),
    .new_word (a_new),
    .rd_data  (a_rd_data),
    .rd_valid (a_rd_valid)
  );

  dp_ram_port_pipe #(
    .DATA_BITS (DATA_BITS),
    .RDW_MODE  (RDW_MODE),
    .OUT_REG   (OUT_REG)
  ) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc      (b_acc),
    .old_word (b_old),
    .new_word (b_new),
    .rd_data  (b_rd_data),
    .rd_valid (b_rd_valid)
  );

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances share stimulus, one read-old with no
// output register, one write-first with output register. A word-level
// model predicts every returned word, valid pulse, busy and collision.
module tb_dp_ram_be;

  localparam int AB = 4;
  localparam int DB = 32;
  localparam int NB = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 0, a_wr_en = 0, b_req = 0, b_wr_en = 0;
  logic [NB-1:0] a_bytesel = '0, b_bytesel = '0;
  logic [AB-1:0] a_addr = '0, b_addr = '0;
  logic [DB-1:0] a_wr_data = '0, b_wr_data = '0;

  logic          busy0, busy1, coll0, coll1;
  logic [DB-1:0] a_rd_data0, b_rd_data0, a_rd_data1, b_rd_data1;
  logic          a_rd_valid0, b_rd_valid0, a_rd_valid1, b_rd_valid1;

  dp_ram_be #(
    .ADDR_BITS (AB), .DATA_BITS (DB), .RDW_MODE (0), .OUT_REG (0), .CLEAR_ON_RESET (1)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .busy (busy0), .collision (coll0),
    .a_req (a_req), .a_wr_en (a_wr_en), .a_bytesel (a_bytesel), .a_addr (a_addr),
    .a_wr_data (a_wr_data), .a_rd_data (a_rd_data0), .a_rd_valid (a_rd_valid0),
    .b_req (b_req), .b_wr_en (b_wr_en), .b_bytesel (b_bytesel), .b_addr (b_addr),
    .b_wr_data (b_wr_data), .b_rd_data (b_rd_data0), .b_rd_valid (b_rd_valid0)
  );

  dp_ram_be #(
    .ADDR_BITS (AB), .DATA_BITS (DB), .RDW_MODE (1), .OUT_REG (1), .CLEAR_ON_RESET (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .busy (busy1), .collision (coll1),
    .a_req (a_req), .a_wr_en (a_wr_en), .a_bytesel (a_bytesel), .a_addr (a_addr),
    .a_wr_data (a_wr_data), .a_rd_data (a_rd_data1), .a_rd_valid (a_rd_valid1),
    .b_req (b_req), .b_wr_en (b_wr_en), .b_bytesel (b_bytesel), .b_addr (b_addr),
    .b_wr_data (b_wr_data), .b_rd_data (b_rd_data1), .b_rd_valid (b_rd_valid1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  typedef struct {
    logic [DB-1:0] d;
    int            due;
  } exp_t;

  exp_t          eq [4][$];          // 0: dut0 A, 1: dut0 B, 2: dut1 A, 3: dut1 B
  logic [DB-1:0] last_d [4];
  logic [DB-1:0] mem_m [DEPTH];
  logic [DB-1:0] bef_a, bef_b;
  int            cyc = 0;
  int            clr_cnt = 0;
  bit            busy_m = 1'b1;
  bit            coll_m = 1'b0;

  function automatic logic [DB-1:0] apply(input logic [DB-1:0] w, input logic [DB-1:0] d,
                                          input logic [NB-1:0] sel);
    logic [DB-1:0] r = w;
    for (int i = 0; i < NB; i++) if (sel[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        eq[k].delete();
        last_d[k] = '0;
      end
      busy_m  = 1'b1;
      clr_cnt = 0;
      coll_m  = 1'b0;
    end else begin
      cyc++;
      coll_m = 1'b0;
      if (!busy_m) begin
        bef_a = mem_m[a_addr];
        bef_b = mem_m[b_addr];
        if (b_req && b_wr_en) mem_m[b_addr] = apply(mem_m[b_addr], b_wr_data, b_bytesel);
        if (a_req && a_wr_en) mem_m[a_addr] = apply(mem_m[a_addr], a_wr_data, a_bytesel);
        if (a_req) begin
          eq[0].push_back('{d: bef_a, due: cyc});
          eq[2].push_back('{d: mem_m[a_addr], due: cyc + 1});
        end
        if (b_req) begin
          eq[1].push_back('{d: bef_b, due: cyc});
          eq[3].push_back('{d: mem_m[b_addr], due: cyc + 1});
        end
        coll_m = a_req && b_req && a_wr_en && b_wr_en && (a_addr == b_addr);
      end else begin
        clr_cnt++;
        if (clr_cnt == DEPTH) begin
          busy_m = 1'b0;
          for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic          act_v [4];
  logic [DB-1:0] act_d [4];
  assign act_v[0] = a_rd_valid0;  assign act_d[0] = a_rd_data0;
  assign act_v[1] = b_rd_valid0;  assign act_d[1] = b_rd_data0;
  assign act_v[2] = a_rd_valid1;  assign act_d[2] = a_rd_data1;
  assign act_v[3] = b_rd_valid1;  assign act_d[3] = b_rd_data1;

  always @(negedge clk) begin
    bit exp_v;
    check("busy0", 32'(busy0), 32'(busy_m));
    check("busy1", 32'(busy1), 32'(busy_m));
    check("collision0", 32'(coll0), 32'(coll_m));
    check("collision1", 32'(coll1), 32'(coll_m));
    for (int k = 0; k < 4; k++) begin
      exp_v = (eq[k].size() > 0) && (eq[k][0].due == cyc);
      if (exp_v) last_d[k] = eq[k].pop_front().d;
      check($sformatf("rd_valid[%0d]", k), 32'(act_v[k]), 32'(exp_v));
      check($sformatf("rd_data[%0d]", k), act_d[k], last_d[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_wr_en = 0; a_bytesel = '0;
    b_req = 0; b_wr_en = 0; b_bytesel = '0;
  endtask

  task automatic op_a(input logic wr, input logic [NB-1:0] sel, input logic [AB-1:0] addr,
                      input logic [DB-1:0] data);
    a_req = 1; a_wr_en = wr; a_bytesel = sel; a_addr = addr; a_wr_data = data;
  endtask

  task automatic op_b(input logic wr, input logic [NB-1:0] sel, input logic [AB-1:0] addr,
                      input logic [DB-1:0] data);
    b_req = 1; b_wr_en = wr; b_bytesel = sel; b_addr = addr; b_wr_data = data;
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check("reset rd_data", a_rd_data0, 32'h0);
    check("reset busy", 32'(busy0), 32'd1);
    rst_n = 1'b1;

    // 1: clear sweep, requests ignored while busy
    op_a(0, 4'h0, 4'd2, 32'h0);
    op_b(1, 4'hF, 4'd3, 32'hFFFF_FFFF);
    wait_clear("clear cycles");
    idle();
    for (int i = 0; i < 8; i++) begin
      op_a(0, 4'h0, 4'(2 * i), 32'h0);
      op_b(0, 4'h0, 4'(2 * i + 1), 32'h0);
      tick();
    end
    idle();
    op_a(0, 4'h0, 4'd3, 32'h0);
    tick(); idle();
    check("ignored write during clear", a_rd_data0, 32'h0);
    tick(); tick();

    // 2: byte enables
    op_a(1, 4'hF, 4'd3, 32'hAABB_CCDD); tick();
    op_a(1, 4'b0101, 4'd3, 32'h1122_3344); tick();
    op_a(0, 4'h0, 4'd3, 32'h0); tick(); idle();
    check("bytesel read rdw0", a_rd_data0, 32'hAA22_CC44);
    tick();
    check("bytesel read rdw1", a_rd_data1, 32'hAA22_CC44);

    // 3: W/W collision at address 5
    op_a(1, 4'b0011, 4'd5, 32'h0000_FFFF);
    op_b(1, 4'b1111, 4'd5, 32'hFFFF_FFFF);
    tick(); idle();
    check("collision pulse", 32'(coll0), 32'd1);
    tick();
    check("collision drop", 32'(coll0), 32'd0);
    op_a(0, 4'h0, 4'd5, 32'h0); tick(); idle();
    check("ww merged", a_rd_data0, 32'hFFFF_FFFF);
    op_a(1, 4'hF, 4'd5, 32'h1234_5678);
    op_b(1, 4'hF, 4'd5, 32'hFFFF_FFFF);
    tick(); idle(); tick();
    check("ww B write-first return", b_rd_data1, 32'h1234_5678);
    op_a(0, 4'h0, 4'd5, 32'h0); tick(); idle();
    check("ww A wins", a_rd_data0, 32'h1234_5678);
    tick();

    // 4: R/W same address
    op_a(1, 4'hF, 4'd7, 32'h1); tick();
    op_a(0, 4'h0, 4'd7, 32'h0);
    op_b(1, 4'hF, 4'd7, 32'h2);
    tick(); idle();
    check("rw read-old", a_rd_data0, 32'h1);
    tick();
    check("rw write-first", a_rd_data1, 32'h2);

    // 5: read stream every cycle with back-to-back writes from B
    for (int i = 0; i < 16; i++) begin
      op_a(0, 4'h0, 4'(i), 32'h0);
      op_b(1, 4'(4'hF >> (i % 3)), 4'(i + 1), 32'hC0DE_0000 + 32'(i));
      tick();
    end
    idle();
    tick(); tick();

    // 6: reset mid-read, then reset mid-sweep at ptr 7
    op_a(0, 4'h0, 4'd5, 32'h0);
    op_b(0, 4'h0, 4'd7, 32'h0);
    tick();
    rst_n = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("post-reset rd_data", a_rd_data1, 32'h0);
    wait_clear("restarted clear cycles");
    op_a(0, 4'h0, 4'd5, 32'h0); tick(); idle();
    check("cleared word", a_rd_data0, 32'h0);
    check("cleared valid", 32'(a_rd_valid0), 32'd1);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
